ctrl_pipe: RTL and testbench

Consumer side of the decoder's control bundle. Carries the decoded control signals down the pipeline through the ID/EX, EX/MEM and MEM/WB registers. Detects load-use and branch-operand hazards and generates stall and flush signals for the fetch stage. Produces EX-stage forwarding selects and keeps saturating stall and flush event counters.

---
 rtl/ctrl_pipe_pkg.sv | 38 +++
 rtl/ctrl_pipe_hazard_fwd_unit.sv | 85 ++++++++
 rtl/ctrl_pipe.sv | 192 +++++++++++++++++++
 tb/tb_ctrl_pipe.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pipe_pkg
//  Purpose  : Shared encodings and the ID/EX control bundle type for the
//             control pipeline (ctrl_pipe) and its hazard/forwarding unit.
//  Contents : ALU nop code, pc_src encodings, forwarding-select encodings,
//             ex_ctrl_t packed struct and the bubble value for it.
//  Revision : 1.0 - initial release
// ============================================================================
package ctrl_pipe_pkg;

  localparam logic [2:0] ALUOP_NOP = 3'b111;

  localparam logic [1:0] PCSRC_SEQ = 2'd0;
  localparam logic [1:0] PCSRC_BR  = 2'd1;
  localparam logic [1:0] PCSRC_JMP = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

  typedef struct packed {
    logic       regWrite;
    logic       memRead;
    logic       memWrite;
    logic       memToReg;
    logic       ALUsrc;
    logic [2:0] ALUop;
  } ex_ctrl_t;

  // A bubble does nothing: no writes, no memory access, ALU nop.
  localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
    regWrite: 1'b0, memRead: 1'b0, memWrite: 1'b0,
    memToReg: 1'b0, ALUsrc: 1'b0, ALUop: ALUOP_NOP
  };

endpackage : ctrl_pipe_pkg
`default_nettype wire

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_fwd_unit
//  Purpose  : Purely combinational hazard detection, branch resolution and
//             EX-stage operand forwarding selects.
//  Ports    : i_id_*   - branch/jump controls and register fields in ID
//             i_ex_*   - ID/EX register state (memRead, regWrite, dest, rs, rt)
//             i_mem_*  - EX/MEM regWrite and dest
//             i_wb_*   - MEM/WB regWrite and dest
//             o_stall  - hold PC and IF/ID, bubble into ID/EX
//             o_taken  - control transfer resolved in ID this cycle
//             o_pc_src - next-PC select
//             o_fwdA/B - EX operand selects
//  Revision : 1.0 - initial release
// ============================================================================
module hazard_fwd_unit
  import ctrl_pipe_pkg::*;
#(
  parameter int RA_W = 5
) (
  input  logic            i_id_beq,
  input  logic            i_id_bne,
  input  logic            i_id_j,
  input  logic            i_id_equal,
  input  logic [RA_W-1:0] i_id_rs,
  input  logic [RA_W-1:0] i_id_rt,
  input  logic            i_ex_memRead,
  input  logic            i_ex_regWrite,
  input  logic [RA_W-1:0] i_ex_dest,
  input  logic [RA_W-1:0] i_ex_rs,
  input  logic [RA_W-1:0] i_ex_rt,
  input  logic            i_mem_regWrite,
  input  logic [RA_W-1:0] i_mem_dest,
  input  logic            i_wb_regWrite,
  input  logic [RA_W-1:0] i_wb_dest,
  output logic            o_stall,
  output logic            o_taken,
  output logic [1:0]      o_pc_src,
  output logic [1:0]      o_fwdA,
  output logic [1:0]      o_fwdB
);

  logic w_ex_hits_id;
  logic w_load_use;
  logic w_branch_haz;
  logic w_stall;
  logic w_taken;

  // Register 0 is hard-wired, so it can never be a real producer.
  assign w_ex_hits_id = (i_ex_dest != '0) &&
                        ((i_ex_dest == i_id_rs) || (i_ex_dest == i_id_rt));

  assign w_load_use   = i_ex_memRead && w_ex_hits_id;
  // Branch compares in ID, so an ALU result still in EX cannot be forwarded.
  assign w_branch_haz = (i_id_beq || i_id_bne) && i_ex_regWrite && w_ex_hits_id;
  assign w_stall      = w_load_use || w_branch_haz;

  assign w_taken = !w_stall &&
                   ((i_id_beq && i_id_equal) || (i_id_bne && !i_id_equal) || i_id_j);

  always_comb begin
    o_pc_src = PCSRC_SEQ;
    if (!w_stall) begin
      if (i_id_j)       o_pc_src = PCSRC_JMP;
      else if (w_taken) o_pc_src = PCSRC_BR;
    end
  end

  // The younger producer (EX/MEM) holds the newest value, so it wins.
  function automatic logic [1:0] f_fwd_sel(input logic [RA_W-1:0] src);
    if (i_mem_regWrite && (i_mem_dest != '0) && (i_mem_dest == src))
      return FWD_MEM;
    else if (i_wb_regWrite && (i_wb_dest != '0) && (i_wb_dest == src))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  assign o_fwdA  = f_fwd_sel(i_ex_rs);
  assign o_fwdB  = f_fwd_sel(i_ex_rt);
  assign o_stall = w_stall;
  assign o_taken = w_taken;

endmodule : hazard_fwd_unit
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : ctrl_pipe
//  Purpose  : Carries decoded controls through ID/EX, EX/MEM and MEM/WB,
//             drives fetch-stage stall/flush/pc_src, EX forwarding selects,
//             and keeps saturating stall and flush event counters.
//  Ports    : clk, rst (async, active-high)
//             id_*            - decoded bundle of the instruction in ID
//             pc_write, ifid_write, ifid_flush, pc_src - fetch control
//             ex_*, mem_*, wb_* - pipeline register contents
//             fwdA, fwdB      - EX operand selects
//             stall_cnt, flush_cnt - saturating event counters
//  Revision : 1.0 - initial release
// ============================================================================
module ctrl_pipe
  import ctrl_pipe_pkg::*;
#(
  parameter int RA_W  = 5,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_regWrite,
  input  logic             id_memToReg,
  input  logic             id_memRead,
  input  logic             id_memWrite,
  input  logic             id_ALUsrc,
  input  logic             id_regDest,
  input  logic             id_beq,
  input  logic             id_bne,
  input  logic             id_j,
  input  logic [2:0]       id_ALUop,
  input  logic             id_equal,
  input  logic [RA_W-1:0]  id_rs,
  input  logic [RA_W-1:0]  id_rt,
  input  logic [RA_W-1:0]  id_rd,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic [1:0]       pc_src,
  output logic             ex_regWrite,
  output logic             ex_memRead,
  output logic             ex_memWrite,
  output logic             ex_memToReg,
  output logic             ex_ALUsrc,
  output logic [2:0]       ex_ALUop,
  output logic [RA_W-1:0]  ex_rs,
  output logic [RA_W-1:0]  ex_rt,
  output logic [RA_W-1:0]  ex_dest,
  output logic             mem_regWrite,
  output logic             mem_memRead,
  output logic             mem_memWrite,
  output logic             mem_memToReg,
  output logic [RA_W-1:0]  mem_dest,
  output logic             wb_regWrite,
  output logic             wb_memToReg,
  output logic [RA_W-1:0]  wb_dest,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // ID/EX
  ex_ctrl_t        r_ex;
  logic [RA_W-1:0] r_ex_rs;
  logic [RA_W-1:0] r_ex_rt;
  logic [RA_W-1:0] r_ex_dest;
  // EX/MEM
  logic            r_mem_regWrite;
  logic            r_mem_memRead;
  logic            r_mem_memWrite;
  logic            r_mem_memToReg;
  logic [RA_W-1:0] r_mem_dest;
  // MEM/WB
  logic            r_wb_regWrite;
  logic            r_wb_memToReg;
  logic [RA_W-1:0] r_wb_dest;
  // Event counters
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic     w_stall;
  logic     w_taken;
  ex_ctrl_t w_id_ctrl;

  hazard_fwd_unit #(
    .RA_W (RA_W)
  ) u_hazard_fwd (
    .i_id_beq       (id_beq),
    .i_id_bne       (id_bne),
    .i_id_j         (id_j),
    .i_id_equal     (id_equal),
    .i_id_rs        (id_rs),
    .i_id_rt        (id_rt),
    .i_ex_memRead   (r_ex.memRead),
    .i_ex_regWrite  (r_ex.regWrite),
    .i_ex_dest      (r_ex_dest),
    .i_ex_rs        (r_ex_rs),
    .i_ex_rt        (r_ex_rt),
    .i_mem_regWrite (r_mem_regWrite),
    .i_mem_dest     (r_mem_dest),
    .i_wb_regWrite  (r_wb_regWrite),
    .i_wb_dest      (r_wb_dest),
    .o_stall        (w_stall),
    .o_taken        (w_taken),
    .o_pc_src       (pc_src),
    .o_fwdA         (fwdA),
    .o_fwdB         (fwdB)
  );

  assign w_id_ctrl = '{
    regWrite: id_regWrite, memRead: id_memRead, memWrite: id_memWrite,
    memToReg: id_memToReg, ALUsrc: id_ALUsrc, ALUop: id_ALUop
  };

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex           <= EX_CTRL_BUBBLE;
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_dest      <= '0;
      r_mem_regWrite <= 1'b0;
      r_mem_memRead  <= 1'b0;
      r_mem_memWrite <= 1'b0;
      r_mem_memToReg <= 1'b0;
      r_mem_dest     <= '0;
      r_wb_regWrite  <= 1'b0;
      r_wb_memToReg  <= 1'b0;
      r_wb_dest      <= '0;
      r_stall_cnt    <= '0;
      r_flush_cnt    <= '0;
    end else begin
      if (w_stall) begin
        r_ex      <= EX_CTRL_BUBBLE;
        r_ex_rs   <= '0;
        r_ex_rt   <= '0;
        r_ex_dest <= '0;
      end else begin
        r_ex      <= w_id_ctrl;
        r_ex_rs   <= id_rs;
        r_ex_rt   <= id_rt;
        r_ex_dest <= id_regDest ? id_rd : id_rt;
      end

      r_mem_regWrite <= r_ex.regWrite;
      r_mem_memRead  <= r_ex.memRead;
      r_mem_memWrite <= r_ex.memWrite;
      r_mem_memToReg <= r_ex.memToReg;
      r_mem_dest     <= r_ex_dest;

      r_wb_regWrite  <= r_mem_regWrite;
      r_wb_memToReg  <= r_mem_memToReg;
      r_wb_dest      <= r_mem_dest;

      // Counters stick at all-ones rather than wrapping.
      if (w_stall && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_taken && (r_flush_cnt != '1))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign pc_write     = !w_stall;
  assign ifid_write   = !w_stall;
  assign ifid_flush   = w_taken;

  assign ex_regWrite  = r_ex.regWrite;
  assign ex_memRead   = r_ex.memRead;
  assign ex_memWrite  = r_ex.memWrite;
  assign ex_memToReg  = r_ex.memToReg;
  assign ex_ALUsrc    = r_ex.ALUsrc;
  assign ex_ALUop     = r_ex.ALUop;
  assign ex_rs        = r_ex_rs;
  assign ex_rt        = r_ex_rt;
  assign ex_dest      = r_ex_dest;

  assign mem_regWrite = r_mem_regWrite;
  assign mem_memRead  = r_mem_memRead;
  assign mem_memWrite = r_mem_memWrite;
  assign mem_memToReg = r_mem_memToReg;
  assign mem_dest     = r_mem_dest;

  assign wb_regWrite  = r_wb_regWrite;
  assign wb_memToReg  = r_wb_memToReg;
  assign wb_dest      = r_wb_dest;

  assign stall_cnt    = r_stall_cnt;
  assign flush_cnt    = r_flush_cnt;

endmodule : ctrl_pipe
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ctrl_pipe
//  Purpose  : Self-checking bench for ctrl_pipe: a table of per-cycle ID
//             bundles with hand-computed outputs, then directed sequences for
//             asynchronous reset mid-stall and counter saturation.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

  localparam int RA_W  = 5;
  localparam int CNT_W = 4;   // small so saturation is reachable quickly

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             id_regWrite, id_memToReg, id_memRead, id_memWrite;
  logic             id_ALUsrc, id_regDest, id_beq, id_bne, id_j, id_equal;
  logic [2:0]       id_ALUop;
  logic [RA_W-1:0]  id_rs, id_rt, id_rd;
  logic             pc_write, ifid_write, ifid_flush;
  logic [1:0]       pc_src;
  logic             ex_regWrite, ex_memRead, ex_memWrite, ex_memToReg, ex_ALUsrc;
  logic [2:0]       ex_ALUop;
  logic [RA_W-1:0]  ex_rs, ex_rt, ex_dest;
  logic             mem_regWrite, mem_memRead, mem_memWrite, mem_memToReg;
  logic [RA_W-1:0]  mem_dest;
  logic             wb_regWrite, wb_memToReg;
  logic [RA_W-1:0]  wb_dest;
  logic [1:0]       fwdA, fwdB;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  ctrl_pipe #(.RA_W(RA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_regWrite(id_regWrite), .id_memToReg(id_memToReg), .id_memRead(id_memRead),
    .id_memWrite(id_memWrite), .id_ALUsrc(id_ALUsrc), .id_regDest(id_regDest),
    .id_beq(id_beq), .id_bne(id_bne), .id_j(id_j), .id_ALUop(id_ALUop),
    .id_equal(id_equal), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
    .pc_src(pc_src),
    .ex_regWrite(ex_regWrite), .ex_memRead(ex_memRead), .ex_memWrite(ex_memWrite),
    .ex_memToReg(ex_memToReg), .ex_ALUsrc(ex_ALUsrc), .ex_ALUop(ex_ALUop),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .mem_regWrite(mem_regWrite), .mem_memRead(mem_memRead),
    .mem_memWrite(mem_memWrite), .mem_memToReg(mem_memToReg), .mem_dest(mem_dest),
    .wb_regWrite(wb_regWrite), .wb_memToReg(wb_memToReg), .wb_dest(wb_dest),
    .fwdA(fwdA), .fwdB(fwdB), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw, m2r, mr, mw, asrc, rdst, beq, bne, j, eq;
    logic [2:0] aluop;
    logic [4:0] rs, rt, rd;
  } id_t;

  typedef struct {
    logic       pcw, flush;
    logic [1:0] pcsrc, fa, fb;
    logic       ex_rw, ex_mr, ex_as;
    logic [2:0] ex_aluop;
    logic [4:0] ex_dest;
    logic       mem_mr;
    logic [4:0] mem_dest;
    logic       wb_rw, wb_m2r;
    logic [4:0] wb_dest;
  } exp_t;

  typedef struct { id_t in; exp_t ex; } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic id_t mk_nop();
    id_t x = '{default: '0};
    x.aluop = 3'b111;
    return x;
  endfunction
  function automatic id_t mk_add(input logic [4:0] rd, rs, rt);
    id_t x = mk_nop();
    x.rw = 1'b1; x.rdst = 1'b1; x.aluop = 3'b010;
    x.rs = rs; x.rt = rt; x.rd = rd;
    return x;
  endfunction
  function automatic id_t mk_lw(input logic [4:0] rt, rs);
    id_t x = mk_nop();
    x.rw = 1'b1; x.m2r = 1'b1; x.mr = 1'b1; x.asrc = 1'b1; x.aluop = 3'b000;
    x.rs = rs; x.rt = rt;
    return x;
  endfunction
  function automatic id_t mk_br(input logic is_beq, input logic eq, input logic [4:0] rs, rt);
    id_t x = mk_nop();
    x.beq = is_beq; x.bne = !is_beq; x.eq = eq; x.aluop = 3'b001;
    x.rs = rs; x.rt = rt;
    return x;
  endfunction
  function automatic id_t mk_j();
    id_t x = mk_nop();
    x.j = 1'b1;
    return x;
  endfunction

  function automatic exp_t mk_exp(
    input logic pcw, flush, input logic [1:0] pcsrc, fa, fb,
    input logic ex_rw, ex_mr, ex_as, input logic [2:0] ex_aluop, input logic [4:0] ex_dest,
    input logic mem_mr, input logic [4:0] mem_dest,
    input logic wb_rw, wb_m2r, input logic [4:0] wb_dest);
    exp_t e;
    e.pcw = pcw; e.flush = flush; e.pcsrc = pcsrc; e.fa = fa; e.fb = fb;
    e.ex_rw = ex_rw; e.ex_mr = ex_mr; e.ex_as = ex_as; e.ex_aluop = ex_aluop;
    e.ex_dest = ex_dest; e.mem_mr = mem_mr; e.mem_dest = mem_dest;
    e.wb_rw = wb_rw; e.wb_m2r = wb_m2r; e.wb_dest = wb_dest;
    return e;
  endfunction

  task automatic drive(input id_t x);
    id_regWrite = x.rw;  id_memToReg = x.m2r; id_memRead = x.mr;
    id_memWrite = x.mw;  id_ALUsrc   = x.asrc; id_regDest = x.rdst;
    id_beq      = x.beq; id_bne      = x.bne; id_j       = x.j;
    id_equal    = x.eq;  id_ALUop    = x.aluop;
    id_rs       = x.rs;  id_rt       = x.rt;  id_rd      = x.rd;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic chk_vec(input int i, input exp_t e);
    chk($sformatf("v%0d.pc_write", i),   32'(pc_write),   32'(e.pcw));
    chk($sformatf("v%0d.ifid_write", i), 32'(ifid_write), 32'(e.pcw));
    chk($sformatf("v%0d.ifid_flush", i), 32'(ifid_flush), 32'(e.flush));
    chk($sformatf("v%0d.pc_src", i),     32'(pc_src),     32'(e.pcsrc));
    chk($sformatf("v%0d.fwdA", i),       32'(fwdA),       32'(e.fa));
    chk($sformatf("v%0d.fwdB", i),       32'(fwdB),       32'(e.fb));
    chk($sformatf("v%0d.ex_regWrite", i), 32'(ex_regWrite), 32'(e.ex_rw));
    chk($sformatf("v%0d.ex_memRead", i),  32'(ex_memRead),  32'(e.ex_mr));
    chk($sformatf("v%0d.ex_ALUsrc", i),   32'(ex_ALUsrc),   32'(e.ex_as));
    chk($sformatf("v%0d.ex_ALUop", i),    32'(ex_ALUop),    32'(e.ex_aluop));
    chk($sformatf("v%0d.ex_dest", i),     32'(ex_dest),     32'(e.ex_dest));
    chk($sformatf("v%0d.mem_memRead", i), 32'(mem_memRead), 32'(e.mem_mr));
    chk($sformatf("v%0d.mem_dest", i),    32'(mem_dest),    32'(e.mem_dest));
    chk($sformatf("v%0d.wb_regWrite", i), 32'(wb_regWrite), 32'(e.wb_rw));
    chk($sformatf("v%0d.wb_memToReg", i), 32'(wb_memToReg), 32'(e.wb_m2r));
    chk($sformatf("v%0d.wb_dest", i),     32'(wb_dest),     32'(e.wb_dest));
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".ex_regWrite"}, 32'(ex_regWrite), 0);
    chk({tag, ".ex_memRead"},  32'(ex_memRead),  0);
    chk({tag, ".ex_memWrite"}, 32'(ex_memWrite), 0);
    chk({tag, ".ex_memToReg"}, 32'(ex_memToReg), 0);
    chk({tag, ".ex_ALUop"},    32'(ex_ALUop),    32'h7);
    chk({tag, ".ex_dest"},     32'(ex_dest),     0);
    chk({tag, ".mem_regWrite"}, 32'(mem_regWrite), 0);
    chk({tag, ".mem_memWrite"}, 32'(mem_memWrite), 0);
    chk({tag, ".mem_memToReg"}, 32'(mem_memToReg), 0);
    chk({tag, ".wb_regWrite"},  32'(wb_regWrite),  0);
    chk({tag, ".stall_cnt"},    32'(stall_cnt),    0);
    chk({tag, ".flush_cnt"},    32'(flush_cnt),    0);
    chk({tag, ".pc_write"},     32'(pc_write),     1);
    chk({tag, ".ifid_flush"},   32'(ifid_flush),   0);
    chk({tag, ".fwdA"},         32'(fwdA),         0);
  endtask

  vec_t vecs[16];

  initial begin
    // Each row: ID bundle presented this cycle, outputs expected before the next edge.
    vecs[0]  = '{mk_lw(5'd8, 5'd1),            mk_exp(1,0,0,0,0, 0,0,0,3'b111, 0, 0, 0, 0,0, 0)};
    vecs[1]  = '{mk_add(5'd9, 5'd8, 5'd2),     mk_exp(0,0,0,0,0, 1,1,1,3'b000, 8, 0, 0, 0,0, 0)};
    vecs[2]  = '{mk_add(5'd9, 5'd8, 5'd2),     mk_exp(1,0,0,0,0, 0,0,0,3'b111, 0, 1, 8, 0,0, 0)};
    vecs[3]  = '{mk_add(5'd3, 5'd4, 5'd5),     mk_exp(1,0,0,1,0, 1,0,0,3'b010, 9, 0, 0, 1,1, 8)};
    vecs[4]  = '{mk_add(5'd3, 5'd6, 5'd7),     mk_exp(1,0,0,0,0, 1,0,0,3'b010, 3, 0, 9, 0,0, 0)};
    vecs[5]  = '{mk_add(5'd10, 5'd3, 5'd3),    mk_exp(1,0,0,0,0, 1,0,0,3'b010, 3, 0, 3, 1,0, 9)};
    vecs[6]  = '{mk_add(5'd0, 5'd3, 5'd9),     mk_exp(1,0,0,2,2, 1,0,0,3'b010, 10,0, 3, 1,0, 3)};
    vecs[7]  = '{mk_add(5'd11, 5'd0, 5'd0),    mk_exp(1,0,0,1,0, 1,0,0,3'b010, 0, 0, 10,1,0, 3)};
    vecs[8]  = '{mk_nop(),                     mk_exp(1,0,0,0,0, 1,0,0,3'b010, 11,0, 0, 1,0, 10)};
    vecs[9]  = '{mk_br(1, 1, 5'd1, 5'd2),      mk_exp(1,1,1,0,0, 0,0,0,3'b111, 0, 0, 11,1,0, 0)};
    vecs[10] = '{mk_br(0, 1, 5'd1, 5'd2),      mk_exp(1,0,0,0,0, 0,0,0,3'b001, 2, 0, 0, 1,0, 11)};
    vecs[11] = '{mk_j(),                       mk_exp(1,1,2,0,0, 0,0,0,3'b001, 2, 0, 2, 0,0, 0)};
    vecs[12] = '{mk_add(5'd5, 5'd1, 5'd2),     mk_exp(1,0,0,0,0, 0,0,0,3'b111, 0, 0, 2, 0,0, 2)};
    vecs[13] = '{mk_br(1, 1, 5'd5, 5'd6),      mk_exp(0,0,0,0,0, 1,0,0,3'b010, 5, 0, 0, 0,0, 2)};
    vecs[14] = '{mk_br(1, 1, 5'd5, 5'd6),      mk_exp(1,1,1,0,0, 0,0,0,3'b111, 0, 0, 5, 0,0, 0)};
    vecs[15] = '{mk_nop(),                     mk_exp(1,0,0,1,0, 0,0,0,3'b001, 6, 0, 0, 1,0, 5)};

    drive(mk_nop());
    #1 rst = 1'b1;
    #2 chk_reset_state("reset");

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(vecs[i].in);
      #2 chk_vec(i, vecs[i].ex);
      @(negedge clk);
    end
    chk("table.stall_cnt", 32'(stall_cnt), 32'd2);
    chk("table.flush_cnt", 32'(flush_cnt), 32'd3);

    // Reset in the middle of a load-use stall clears state without a clock edge.
    drive(mk_lw(5'd8, 5'd1));
    @(negedge clk);
    drive(mk_add(5'd9, 5'd8, 5'd2));
    #2 chk("midrst.pre_stall", 32'(pc_write), 32'd0);
    #1 rst = 1'b1;
    #1 chk_reset_state("midrst");
    @(negedge clk);
    rst = 1'b0;
    #2 chk("midrst.first_cycle_no_stall", 32'(pc_write), 32'd1);
    @(negedge clk);

    // 2^CNT_W + 3 load-use stalls: counter must pin at all-ones.
    for (int i = 0; i < (1 << CNT_W) + 3; i++) begin
      drive(mk_lw(5'd8, 5'd1));
      #2 if (i == 10) chk("sat.stall_cnt_mid", 32'(stall_cnt), 32'd10);
      @(negedge clk);
      drive(mk_add(5'd9, 5'd8, 5'd2));
      #2 if (i == 0) chk("sat.stall_seen", 32'(pc_write), 32'd0);
      @(negedge clk);
    end
    drive(mk_nop());
    #2 chk("sat.stall_cnt", 32'(stall_cnt), 32'hF);

    // Back-to-back jumps flush every cycle.
    for (int i = 0; i < (1 << CNT_W) + 4; i++) begin
      @(negedge clk);
      drive(mk_j());
    end
    @(negedge clk);
    drive(mk_nop());
    #2 chk("sat.flush_cnt", 32'(flush_cnt), 32'hF);
    chk("sat.stall_cnt_hold", 32'(stall_cnt), 32'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ctrl_pipe
`default_nettype wire
